// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end of the 16-bit pipeline. Owns the architectural
//   PC, fetches from a variable-latency instruction memory with a req/ready
//   handshake, and hands instructions to decode through an output pipeline
//   register. A one-entry skid buffer holds a word that arrives while decode
//   is stalled. Fetch stops on an HLT opcode until a redirect or reset.
//
// Ports
//   clk         in   1   clock, all state on rising edge
//   rst_n       in   1   synchronous active-low reset
//   branching   in   1   redirect request from writeback
//   next_pc     in   16  redirect target (bit 0 forced to 0)
//   stall       in   1   decode cannot accept a new instruction this cycle
//   imem_req    out  1   instruction memory request (FETCH state only)
//   imem_addr   out  16  fetch address, always equal to the PC
//   imem_ready  in   1   imem_data valid for the current imem_addr
//   imem_data   in   16  fetched instruction word
//   instr       out  16  registered instruction to decode
//   pc_plus2    out  16  registered address of instr + 2
//   instr_valid out  1   instr/pc_plus2 hold a real instruction
//   halted      out  1   fetch stopped on HLT
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branching,
  input  logic [15:0] next_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic [15:0] skid_q, skid_d;

  logic [15:0] pc_inc;
  logic        data_is_hlt;
  logic        skid_is_hlt;

  // The fetch address is the PC; +2 wraps modulo 2^16 with no flag.
  assign pc_inc      = pc_q + 16'd2;
  assign data_is_hlt = (imem_data[15:12] == HLT_OPCODE);
  assign skid_is_hlt = (skid_q[15:12] == HLT_OPCODE);

  // Moore outputs. The request is masked while reset is held so the memory
  // never sees a request from a state that is about to be discarded.
  assign imem_req    = rst_n && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign halted      = (state_q == HALT);
  assign instr       = instr_q;
  assign pc_plus2    = pc_plus2_q;
  assign instr_valid = valid_q;

  // Next-state logic. A redirect overrides everything except reset: it
  // discards any same-cycle memory response and the skid contents, and
  // ignores stall on that edge. Otherwise each state decides whether the
  // output register loads, bubbles or holds.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    skid_d     = skid_q;

    if (branching) begin
      pc_d    = next_pc & 16'hFFFE;
      state_d = FETCH;
      valid_d = 1'b0;
      skid_d  = 16'h0000;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (!stall) begin
              instr_d    = imem_data;
              pc_plus2_d = pc_inc;
              valid_d    = 1'b1;
              if (data_is_hlt) begin
                state_d = HALT;
              end else begin
                pc_d = pc_inc;
              end
            end else begin
              // Decode is busy: park the word and stop requesting.
              skid_d  = imem_data;
              state_d = HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end

        HOLD: begin
          if (!stall) begin
            instr_d    = skid_q;
            pc_plus2_d = pc_inc;
            valid_d    = 1'b1;
            skid_d     = 16'h0000;
            if (skid_is_hlt) begin
              state_d = HALT;
            end else begin
              pc_d    = pc_inc;
              state_d = FETCH;
            end
          end
        end

        HALT: begin
          // The HLT word stays visible until decode takes it.
          if (!stall) begin
            valid_d = 1'b0;
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous reset. Reset drops any outstanding
  // request, so a late memory response is never consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
      skid_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Randomized bench for fetch_stage. The stimulus process drives reset,
//   redirects, stall and memory ready; whenever the program flow restarts it
//   queues the instruction stream decode should see from that point. A
//   separate monitor pops that queue each time decode actually takes an
//   instruction (instr_valid high, no stall, no redirect, no reset).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcPlus2;
  } expEntry_t;

  logic        clk;
  logic        rst_n;
  logic        branching;
  logic [15:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        halted;

  expEntry_t   expQ[$];
  int          errors = 0;
  int          checks = 0;
  int          consumed = 0;
  bit          haltReached = 0;
  int          sinceRedir = 0;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .HLT_OPCODE(4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .branching  (branching),
    .next_pc    (next_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .instr      (instr),
    .pc_plus2   (pc_plus2),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: a few fixed words at the bottom, a hash elsewhere with
  // HLT made rare so streams run for a while before halting.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    logic [15:0] h;
    case (a)
      16'h0000: h = 16'h1234;
      16'h0002: h = 16'h2345;
      16'h0004: h = 16'h3456;
      16'h0006: h = 16'hF000;
      default: begin
        h = (a * 16'd40503) ^ 16'h3C5A;
        if (h[15:12] == 4'hF && h[3:0] > 4'd5) h[15:12] = 4'hE;
      end
    endcase
    return h;
  endfunction

  // Combinational memory: data always matches the presented address.
  assign imem_data = memWord(imem_addr);

  // Queues the sequential program stream decode should see from an address.
  task automatic startStream(input logic [15:0] target);
    logic [15:0] a;
    expEntry_t   e;
    expQ.delete();
    haltReached = 0;
    a = target;
    for (int k = 0; k < 80; k++) begin
      e.instr   = memWord(a);
      e.pcPlus2 = a + 16'd2;
      expQ.push_back(e);
      if (e.instr[15:12] == 4'hF) break;
      a = a + 16'd2;
    end
  endtask

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One random cycle of environment behaviour.
  task automatic applyStimulus();
    int r;
    nextCycle();
    branching = 1'b0;
    rst_n     = 1'b1;
    r = $urandom % 100;
    sinceRedir++;
    if (r < 2) begin
      rst_n = 1'b0;
      startStream(RESET_PC);
      sinceRedir = 0;
    end else if (r < 7 || sinceRedir >= 60) begin
      branching = 1'b1;
      next_pc   = ($urandom % 8 == 0) ? 16'hFFFC : 16'($urandom);
      startStream(next_pc & 16'hFFFE);
      sinceRedir = 0;
    end
    imem_ready = ($urandom % 100) < 60;
    stall      = ($urandom % 100) < 30;
  endtask

  // Monitor: samples on the falling edge, where inputs for the coming edge
  // and the registered outputs are both stable.
  initial begin
    bit          prevRstLow = 0;
    bit          prevBranch = 0;
    logic [15:0] prevTgt = 16'h0000;
    expEntry_t   e;
    forever begin
      @(negedge clk);
      if (!rst_n) checkOutput("req_in_reset", {15'b0, imem_req}, 16'h0000);
      if (prevRstLow) begin
        checkOutput("rst_instr", instr, 16'h0000);
        checkOutput("rst_pc_plus2", pc_plus2, 16'h0000);
        checkOutput("rst_valid", {15'b0, instr_valid}, 16'h0000);
        checkOutput("rst_halted", {15'b0, halted}, 16'h0000);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_req", {15'b0, imem_req}, {15'b0, rst_n});
      end else if (prevBranch) begin
        checkOutput("redir_valid", {15'b0, instr_valid}, 16'h0000);
        checkOutput("redir_addr", imem_addr, prevTgt);
        checkOutput("redir_halted", {15'b0, halted}, 16'h0000);
        checkOutput("redir_req", {15'b0, imem_req}, {15'b0, rst_n});
      end else if (haltReached && rst_n) begin
        checkOutput("halt_flag", {15'b0, halted}, 16'h0001);
        checkOutput("halt_req", {15'b0, imem_req}, 16'h0000);
      end
      if (rst_n && !branching && instr_valid && !stall) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_instr actual=%h required=none at %0t", instr, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("instr", instr, e.instr);
          checkOutput("pc_plus2", pc_plus2, e.pcPlus2);
          consumed++;
          if (e.instr[15:12] == 4'hF) haltReached = 1;
        end
      end
      prevRstLow = !rst_n;
      prevBranch = branching && rst_n;
      prevTgt    = next_pc & 16'hFFFE;
    end
  end

  // Directed opening with zero-wait memory, then a long random run.
  initial begin
    rst_n      = 1'b0;
    branching  = 1'b0;
    next_pc    = 16'h0000;
    stall      = 1'b0;
    imem_ready = 1'b1;
    startStream(RESET_PC);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) nextCycle();
    checkOutput("zero_wait_count", 16'(consumed), 16'd4);
    for (int i = 0; i < 3; i++) nextCycle();
    branching = 1'b1;
    next_pc   = 16'h0041;
    startStream(16'h0040);
    nextCycle();
    branching = 1'b0;
    for (int i = 0; i < 3000; i++) applyStimulus();
    nextCycle();
    branching = 1'b0;
    rst_n     = 1'b1;
    checks++;
    if (consumed < 300) begin
      errors++;
      $display("[TB] FAIL throughput actual=%0d required>=300", consumed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
